// File: rtl/ctrl_conv_input_if.sv
// Handshake and memory-write bundle of the convolution input controller.
// slave: controller side; master: upstream producer / memories / output controller side.
interface ctrl_conv_input_if #(
  parameter int unsigned T                = 8,
  parameter int unsigned X_MEM_ADDR_WIDTH = 3,
  parameter int unsigned F_MEM_ADDR_WIDTH = 2
);
  // X stream
  logic [T-1:0]                s_data_in_x;
  logic                        s_valid_x;
  logic                        s_ready_x;
  // F stream
  logic [T-1:0]                s_data_in_f;
  logic                        s_valid_f;
  logic                        s_ready_f;
  // X_mem write port
  logic                        x_wr_en;
  logic [X_MEM_ADDR_WIDTH-1:0] x_addr;
  logic [T-1:0]                x_data;
  // F_mem write port
  logic                        f_wr_en;
  logic [F_MEM_ADDR_WIDTH-1:0] f_addr;
  logic [T-1:0]                f_data;
  // Convolution control
  logic                        conv_start;
  logic                        conv_done;

  modport slave (
    input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, conv_done,
    output s_ready_x, s_ready_f, x_wr_en, x_addr, x_data, f_wr_en, f_addr, f_data, conv_start
  );

  modport master (
    output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f, conv_done,
    input  s_ready_x, s_ready_f, x_wr_en, x_addr, x_data, f_wr_en, f_addr, f_data, conv_start
  );
endinterface

// File: rtl/ctrl_conv_input.sv
// Input-side controller of the convolution datapath: loads F_mem and X_mem from two
// independent streams, then holds conv_start until the output side reports conv_done.
module ctrl_conv_input #(
  parameter int unsigned F_MEM_SIZE       = 4,
  parameter int unsigned X_MEM_SIZE       = 8,
  parameter int unsigned X_MEM_ADDR_WIDTH = 3,
  parameter int unsigned F_MEM_ADDR_WIDTH = 2,
  parameter int unsigned T                = 8
) (
  input logic              clk,
  input logic              reset_n,
  ctrl_conv_input_if.slave conv_if
);

  // Counters carry one extra bit so they can hold the full memory size.
  localparam int unsigned XCntW = X_MEM_ADDR_WIDTH + 1;
  localparam int unsigned FCntW = F_MEM_ADDR_WIDTH + 1;

  localparam logic [XCntW-1:0] XSize = XCntW'(X_MEM_SIZE);
  localparam logic [FCntW-1:0] FSize = FCntW'(F_MEM_SIZE);
  localparam logic [XCntW-1:0] XLast = XCntW'(X_MEM_SIZE - 1);
  localparam logic [FCntW-1:0] FLast = FCntW'(F_MEM_SIZE - 1);
  localparam logic [XCntW-1:0] XOne  = XCntW'(1);
  localparam logic [FCntW-1:0] FOne  = FCntW'(1);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e             state_q, state_d;
  logic [XCntW-1:0]   x_cnt_q, x_cnt_d;
  logic [FCntW-1:0]   f_cnt_q, f_cnt_d;

  logic               x_ready, f_ready;
  logic               x_hs, f_hs;
  logic               x_full, f_full;

  // Readies, handshakes and "memory full after this cycle" detection.
  always_comb begin
    x_ready = (state_q == StLoad) && (x_cnt_q < XSize);
    f_ready = (state_q == StLoad) && (f_cnt_q < FSize);
    x_hs    = conv_if.s_valid_x && x_ready;
    f_hs    = conv_if.s_valid_f && f_ready;
    // Full either already, or completed by the handshake happening this cycle.
    x_full  = (x_cnt_q == XSize) || (x_hs && (x_cnt_q == XLast));
    f_full  = (f_cnt_q == FSize) || (f_hs && (f_cnt_q == FLast));
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave LOAD once both memories are full, return on conv_done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad: if (x_full && f_full) state_d = StRun;
      StRun:  if (conv_if.conv_done) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  // Counter next-state: count accepted words, clear when the convolution finishes.
  always_comb begin
    x_cnt_d = x_cnt_q;
    f_cnt_d = f_cnt_q;
    if ((state_q == StRun) && conv_if.conv_done) begin
      x_cnt_d = '0;
      f_cnt_d = '0;
    end else begin
      if (x_hs) x_cnt_d = x_cnt_q + XOne;
      if (f_hs) f_cnt_d = f_cnt_q + FOne;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt_q <= '0;
      f_cnt_q <= '0;
    end else begin
      x_cnt_q <= x_cnt_d;
      f_cnt_q <= f_cnt_d;
    end
  end

  // Outputs: zero-latency write path; conv_start decoded from the registered state.
  always_comb begin
    conv_if.s_ready_x  = x_ready;
    conv_if.s_ready_f  = f_ready;
    conv_if.x_wr_en    = x_hs;
    conv_if.x_addr     = x_cnt_q[X_MEM_ADDR_WIDTH-1:0];
    conv_if.x_data     = conv_if.s_data_in_x;
    conv_if.f_wr_en    = f_hs;
    conv_if.f_addr     = f_cnt_q[F_MEM_ADDR_WIDTH-1:0];
    conv_if.f_data     = conv_if.s_data_in_f;
    conv_if.conv_start = (state_q == StRun);
  end

endmodule

// File: tb/tb_ctrl_conv_input.sv
// Directed bench for ctrl_conv_input: inputs driven 1 time unit after the rising edge,
// outputs checked 1 time unit later, well away from either clock edge.
module tb_ctrl_conv_input;

  localparam int unsigned T  = 8;
  localparam int unsigned XW = 3;
  localparam int unsigned FW = 2;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  ctrl_conv_input_if #(.T(T), .X_MEM_ADDR_WIDTH(XW), .F_MEM_ADDR_WIDTH(FW)) cif ();

  ctrl_conv_input #(
    .F_MEM_SIZE       (4),
    .X_MEM_SIZE       (8),
    .X_MEM_ADDR_WIDTH (XW),
    .F_MEM_ADDR_WIDTH (FW),
    .T                (T)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .conv_if (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cif.s_valid_x   = 1'b0;
    cif.s_valid_f   = 1'b0;
    cif.s_data_in_x = '0;
    cif.s_data_in_f = '0;
    cif.conv_done   = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset_n = 1'b0;

    // Reset state
    #3;
    check("rst_ready_x", 32'(cif.s_ready_x), 1);
    check("rst_ready_f", 32'(cif.s_ready_f), 1);
    check("rst_conv_start", 32'(cif.conv_start), 0);
    check("rst_x_wr_en", 32'(cif.x_wr_en), 0);
    check("rst_f_wr_en", 32'(cif.f_wr_en), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // Back-to-back load: F 1..4, X 10..17, valids held high
    for (int c = 0; c < 9; c++) begin
      cif.s_valid_x   = 1'b1;
      cif.s_valid_f   = 1'b1;
      cif.s_data_in_x = T'(10 + c);
      cif.s_data_in_f = T'(1 + c);
      #1;
      if (c < 4) begin
        check("b2b_f_wr_en", 32'(cif.f_wr_en), 1);
        check("b2b_f_addr", 32'(cif.f_addr), 32'(c));
        check("b2b_f_data", 32'(cif.f_data), 32'(1 + c));
      end else begin
        check("b2b_f_ready_low", 32'(cif.s_ready_f), 0);
        check("b2b_f_wr_en_low", 32'(cif.f_wr_en), 0);
      end
      if (c < 8) begin
        check("b2b_x_wr_en", 32'(cif.x_wr_en), 1);
        check("b2b_x_addr", 32'(cif.x_addr), 32'(c));
        check("b2b_x_data", 32'(cif.x_data), 32'(10 + c));
        check("b2b_start_low", 32'(cif.conv_start), 0);
      end else begin
        check("b2b_start_high", 32'(cif.conv_start), 1);
        check("b2b_x_ready_low", 32'(cif.s_ready_x), 0);
        check("b2b_x_wr_en_low", 32'(cif.x_wr_en), 0);
      end
      tick();
    end

    // Blocked in RUN: valid data 0xFF must be ignored
    for (int c = 0; c < 3; c++) begin
      cif.s_valid_x   = 1'b1;
      cif.s_valid_f   = 1'b1;
      cif.s_data_in_x = 8'hFF;
      cif.s_data_in_f = 8'hFF;
      #1;
      check("run_ready_x", 32'(cif.s_ready_x), 0);
      check("run_ready_f", 32'(cif.s_ready_f), 0);
      check("run_x_wr_en", 32'(cif.x_wr_en), 0);
      check("run_f_wr_en", 32'(cif.f_wr_en), 0);
      check("run_x_addr", 32'(cif.x_addr), 0);
      check("run_f_addr", 32'(cif.f_addr), 0);
      check("run_start", 32'(cif.conv_start), 1);
      tick();
    end

    // conv_done re-arm
    idle_inputs();
    cif.conv_done = 1'b1;
    #1;
    check("done_edge_start", 32'(cif.conv_start), 1);
    tick();
    cif.conv_done = 1'b0;
    #1;
    check("rearm_start", 32'(cif.conv_start), 0);
    check("rearm_ready_x", 32'(cif.s_ready_x), 1);
    check("rearm_ready_f", 32'(cif.s_ready_f), 1);
    tick();

    // conv_done in LOAD has no effect
    cif.conv_done = 1'b1;
    tick();
    cif.conv_done = 1'b0;
    #1;
    check("load_done_start", 32'(cif.conv_start), 0);
    check("load_done_ready", 32'(cif.s_ready_x), 1);
    tick();

    // Second load with X bubbles (valid on even cycles), F back-to-back first
    for (int c = 0; c < 16; c++) begin
      cif.s_valid_x   = (c % 2 == 0) && (c < 15);
      cif.s_valid_f   = (c < 4);
      cif.s_data_in_x = T'(8'h20 + c);
      cif.s_data_in_f = T'(8'h40 + c);
      #1;
      if (c < 15) begin
        check("bub_x_wr_en", 32'(cif.x_wr_en), 32'(c % 2 == 0));
        check("bub_x_addr", 32'(cif.x_addr), 32'((c + 1) / 2));
        check("bub_start_low", 32'(cif.conv_start), 0);
      end else begin
        check("bub_start_high", 32'(cif.conv_start), 1);
      end
      if (c < 4) check("bub_f_addr", 32'(cif.f_addr), 32'(c));
      tick();
    end
    idle_inputs();
    cif.conv_done = 1'b1;
    tick();
    cif.conv_done = 1'b0;

    // Asynchronous reset mid-load: 5 X writes then reset between edges
    for (int c = 0; c < 5; c++) begin
      cif.s_valid_x   = 1'b1;
      cif.s_data_in_x = T'(c);
      tick();
    end
    cif.s_valid_x = 1'b0;
    #1;
    check("arst_pre_addr", 32'(cif.x_addr), 5);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_x_addr", 32'(cif.x_addr), 0);
    check("arst_start", 32'(cif.conv_start), 0);
    check("arst_ready_x", 32'(cif.s_ready_x), 1);
    #1;
    reset_n = 1'b1;
    tick();
    cif.s_valid_x   = 1'b1;
    cif.s_data_in_x = 8'h55;
    #1;
    check("arst_first_wr", 32'(cif.x_wr_en), 1);
    check("arst_first_addr", 32'(cif.x_addr), 0);
    tick();
    idle_inputs();
    do_reset();

    // Simultaneous finish: X at cycles 0..7, F at cycles 4..7
    for (int c = 0; c < 8; c++) begin
      cif.s_valid_x   = 1'b1;
      cif.s_valid_f   = (c >= 4);
      cif.s_data_in_x = T'(c);
      cif.s_data_in_f = T'(c);
      #1;
      if (c == 7) begin
        check("sim_x_wr", 32'(cif.x_wr_en), 1);
        check("sim_f_wr", 32'(cif.f_wr_en), 1);
        check("sim_f_addr", 32'(cif.f_addr), 3);
        check("sim_x_addr", 32'(cif.x_addr), 7);
        check("sim_start_low", 32'(cif.conv_start), 0);
      end
      tick();
    end
    idle_inputs();
    #1;
    check("sim_start_high", 32'(cif.conv_start), 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("sim_start_held", 32'(cif.conv_start), 1);
      check("sim_ready_x_low", 32'(cif.s_ready_x), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
